// File: rtl/memory_arbiter.sv
// memory_arbiter: serialises instruction reads and data reads/writes onto a
// single RAM port. Data requests win ties, but an instruction that was
// waiting when a data access started is served next so fetch never starves.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   iREN, iaddr       instruction read request (held until ihit)
//   dREN, dWEN        data read / write request (held until dhit)
//   daddr, dstore     data address and write data
//   ihit, dhit        one-cycle completion pulses (registered)
//   iload, dload      registered read data
//   ramREN, ramWEN    RAM strobes, decoded from state and latched operation
//   ramaddr, ramstore latched RAM address / write data
//   ramload, ramready RAM read data and access-complete handshake
//   err               sticky watchdog flag (ARB_TIMEOUT_EN builds only)
//
// Build option: define ARB_TIMEOUT_EN to add the access watchdog, its
// TIMEOUT parameter (8-bit, default 255) and the err port.
module memory_arbiter (
  input  logic        CLK,
  input  logic        RST,
`ifdef ARB_TIMEOUT_EN
  output logic        err,
`endif
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        ihit,
  output logic        dhit,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready
);

`ifdef ARB_TIMEOUT_EN
  parameter logic [7:0] TIMEOUT = 8'd255;
`endif

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DACC = 2'd1,
    IACC = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic            ipend_q;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   store_q;

  logic            start_d_c;
  logic            start_i_c;
  logic            in_acc_c;
  logic            done_c;
  logic            timeout_c;

  // Next-state decode and RAM strobes.
  always_comb begin
    state_d   = state_q;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    start_d_c = 1'b0;
    start_i_c = 1'b0;
    in_acc_c  = 1'b0;
    done_c    = 1'b0;
    case (state_q)
      IDLE: begin
        // A data request yields only to an instruction it already jumped.
        if ((dREN || dWEN) && !ipend_q) begin
          state_d   = DACC;
          start_d_c = 1'b1;
        end else if (iREN) begin
          state_d   = IACC;
          start_i_c = 1'b1;
        end
      end
      DACC: begin
        in_acc_c = 1'b1;
        ramREN   = ~we_q;
        ramWEN   = we_q;
        if (ramready || timeout_c) begin
          state_d = RESP;
          done_c  = 1'b1;
        end
      end
      IACC: begin
        in_acc_c = 1'b1;
        ramREN   = 1'b1;
        if (ramready || timeout_c) begin
          state_d = RESP;
          done_c  = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latch: address, store data, operation and the owed-fetch flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ipend_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      store_q <= '0;
    end else if (start_d_c) begin
      ipend_q <= iREN;
      we_q    <= dWEN;   // read+write together resolves to a write
      addr_q  <= daddr;
      store_q <= dstore;
    end else if (start_i_c) begin
      ipend_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= iaddr;
    end
  end

  assign ramaddr  = addr_q;
  assign ramstore = store_q;

  // Completion pulses and load capture; a timed-out access keeps old data.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ihit  <= 1'b0;
      dhit  <= 1'b0;
      iload <= '0;
      dload <= '0;
    end else begin
      ihit <= done_c && (state_q == IACC);
      dhit <= done_c && (state_q == DACC);
      if ((state_q == IACC) && ramready) begin
        iload <= ramload;
      end
      if ((state_q == DACC) && ramready && !we_q) begin
        dload <= ramload;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [CW-1:0] wd_cnt_q;

  assign timeout_c = in_acc_c && !ramready && (wd_cnt_q == TIMEOUT);

  // Watchdog: counts stalled access cycles, forces completion at TIMEOUT.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wd_cnt_q <= '0;
      err      <= 1'b0;
    end else begin
      if (start_d_c || start_i_c) begin
        wd_cnt_q <= '0;
      end else if (in_acc_c && !ramready && !timeout_c) begin
        wd_cnt_q <= wd_cnt_q + CW'(1);
      end
      if (timeout_c) begin
        err <= 1'b1;
      end
    end
  end
`else
  assign timeout_c = 1'b0;
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN, ramready;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        ihit, dhit, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;
`ifdef ARB_TIMEOUT_EN
  logic        err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

`ifdef ARB_TIMEOUT_EN
  memory_arbiter #(.TIMEOUT(8'd4)) dut (
    .CLK(CLK), .RST(RST),
    .err(err),
    .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .ihit(ihit), .dhit(dhit),
    .iload(iload), .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload),
    .ramready(ramready)
  );
`else
  memory_arbiter dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .ihit(ihit), .dhit(dhit),
    .iload(iload), .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload),
    .ramready(ramready)
  );
`endif

  // Advance one cycle; outputs are sampled and inputs driven 1 time unit later.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    for (int k = 0; k < 2; k++) begin
      iREN = 1'($urandom_range(1, 0)); dREN = 1'($urandom_range(1, 0));
      dWEN = 1'($urandom_range(1, 0)); ramready = 1'($urandom_range(1, 0));
      iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
      step();
      checks++; if ({ihit, dhit, ramREN, ramWEN} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b exp 0000", {ihit, dhit, ramREN, ramWEN}); end
      checks++; if (iload !== 32'h0 || dload !== 32'h0) begin errors++; $display("FAIL reset_loads got %h %h exp 0 0", iload, dload); end
      checks++; if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin errors++; $display("FAIL reset_ramport got %h %h exp 0 0", ramaddr, ramstore); end
`ifdef ARB_TIMEOUT_EN
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
`endif
    end
    RST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramready = 1'b0;
    step();
    checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin errors++; $display("FAIL reset_idle got %b%b exp 00", ramREN, ramWEN); end
  endtask

  task automatic test_iread();
    iREN = 1'b1; iaddr = 32'h40; ramready = 1'b0; ramload = $urandom;
    step();
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h40) begin errors++; $display("FAIL iread_strobe got %b %h exp 1 00000040", ramREN, ramaddr); end
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL iread_early_hit got %b exp 0", ihit); end
    ramready = 1'b1; ramload = 32'h8C220004;
    step();
    checks++; if (ihit !== 1'b1 || iload !== 32'h8C220004) begin errors++; $display("FAIL iread_hit got %b %h exp 1 8c220004", ihit, iload); end
    checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL iread_resp_strobe got %b exp 0", ramREN); end
    iREN = 1'b0; ramready = 1'b0;
    step();
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL iread_hit_len got %b exp 0", ihit); end
  endtask

  task automatic test_dwrite();
    dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF; ramready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin errors++; $display("FAIL dwrite_strobe c%0d got %b%b exp 01", k, ramREN, ramWEN); end
      checks++; if (ramaddr !== 32'h100 || ramstore !== 32'hDEADBEEF) begin errors++; $display("FAIL dwrite_port c%0d got %h %h exp 00000100 deadbeef", k, ramaddr, ramstore); end
      checks++; if (dhit !== 1'b0) begin errors++; $display("FAIL dwrite_early_hit c%0d got %b exp 0", k, dhit); end
      ramready = (k == 3);
      ramload = $urandom;
    end
    step();
    checks++; if (dhit !== 1'b1 || ramWEN !== 1'b0) begin errors++; $display("FAIL dwrite_hit got %b %b exp 1 0", dhit, ramWEN); end
    checks++; if (dload !== 32'h0) begin errors++; $display("FAIL dwrite_dload got %h exp 0", dload); end
    dWEN = 1'b0; ramready = 1'b0;
    step();
    checks++; if (dhit !== 1'b0) begin errors++; $display("FAIL dwrite_hit_len got %b exp 0", dhit); end
  endtask

  task automatic test_contention();
    iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h200; ramready = 1'b0;
    step();
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h200) begin errors++; $display("FAIL cont_data_first got %b %h exp 1 00000200", ramREN, ramaddr); end
    ramready = 1'b1; ramload = 32'h11111111;
    step();
    checks++; if (dhit !== 1'b1 || ihit !== 1'b0 || dload !== 32'h11111111) begin errors++; $display("FAIL cont_dhit1 got %b %b %h exp 1 0 11111111", dhit, ihit, dload); end
    daddr = 32'h204; ramready = 1'b0;
    step();
    checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL cont_idle1 got %b exp 0", ramREN); end
    step();
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h80) begin errors++; $display("FAIL cont_instr_second got %b %h exp 1 00000080", ramREN, ramaddr); end
    ramready = 1'b1; ramload = 32'h22222222;
    step();
    checks++; if (ihit !== 1'b1 || dhit !== 1'b0 || iload !== 32'h22222222) begin errors++; $display("FAIL cont_ihit got %b %b %h exp 1 0 22222222", ihit, dhit, iload); end
    iREN = 1'b0; ramready = 1'b0;
    step();
    step();
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h204) begin errors++; $display("FAIL cont_data_third got %b %h exp 1 00000204", ramREN, ramaddr); end
    ramready = 1'b1; ramload = 32'h33333333;
    step();
    checks++; if (dhit !== 1'b1 || dload !== 32'h33333333) begin errors++; $display("FAIL cont_dhit2 got %b %h exp 1 33333333", dhit, dload); end
    dREN = 1'b0; ramready = 1'b0;
    step();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    dREN = 1'b1; daddr = 32'h3C; ramready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++; if (dhit !== 1'b0 || ramREN !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL timeout_wait c%0d got %b %b %b exp 0 1 0", k, dhit, ramREN, err); end
    end
    step();
    checks++; if (dhit !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL timeout_fire got %b %b exp 1 1", dhit, err); end
    checks++; if (dload !== 32'h33333333) begin errors++; $display("FAIL timeout_dload got %h exp 33333333", dload); end
    dREN = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (err !== 1'b1 || dhit !== 1'b0) begin errors++; $display("FAIL timeout_sticky got %b %b exp 1 0", err, dhit); end
    end
  endtask
`endif

  task automatic test_reset_mid();
    dREN = 1'b1; daddr = 32'h300; ramready = 1'b0;
    step();
    checks++; if (ramREN !== 1'b1) begin errors++; $display("FAIL rmid_strobe got %b exp 1", ramREN); end
    step();
    RST = 1'b1; dREN = 1'b0;
    step();
    RST = 1'b0;
    checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin errors++; $display("FAIL rmid_drop got %b%b exp 00", ramREN, ramWEN); end
    checks++; if (iload !== 32'h0 || dload !== 32'h0) begin errors++; $display("FAIL rmid_loads got %h %h exp 0 0", iload, dload); end
`ifdef ARB_TIMEOUT_EN
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rmid_err got %b exp 0", err); end
`endif
    for (int k = 0; k < 8; k++) begin
      ramready = (k == 3);
      checks++; if (dhit !== 1'b0 || ramREN !== 1'b0) begin errors++; $display("FAIL rmid_no_hit c%0d got %b %b exp 0 0", k, dhit, ramREN); end
      step();
    end
    ramready = 1'b0;
  endtask

  // Random traffic against a transaction-level model: every held request is
  // served exactly once, data wins unless a fetch was already passed over,
  // reads return the latest value written, and each access costs 1+W cycles
  // followed by one hit cycle and one idle cycle.
  task automatic test_random();
    logic [31:0] ref_mem [16];
    logic [31:0] ram_mem [16];
    int unsigned phase;   // current cycle: 0 idle, 1 access, 2 hit
    int unsigned waits;
    int unsigned op;
    logic        k_data, k_write, owed, i_req, d_req;
    logic [31:0] x_addr, x_store, x_iload, x_dload;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      ram_mem[i] = ref_mem[i];
    end
    RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramready = 1'b0;
    step(); step();
    RST = 1'b0;
    phase = 0; waits = 0; k_data = 1'b0; k_write = 1'b0; owed = 1'b0;
    i_req = 1'b0; d_req = 1'b0;
    x_addr = '0; x_store = '0; x_iload = '0; x_dload = '0;
    for (int c = 0; c < 3000; c++) begin
      checks++; if (ramREN !== ((phase == 1) && !k_write)) begin errors++; $display("FAIL rnd_ren c%0d got %b exp %b", c, ramREN, (phase == 1) && !k_write); end
      checks++; if (ramWEN !== ((phase == 1) && k_write)) begin errors++; $display("FAIL rnd_wen c%0d got %b exp %b", c, ramWEN, (phase == 1) && k_write); end
      checks++; if (ramaddr !== x_addr) begin errors++; $display("FAIL rnd_addr c%0d got %h exp %h", c, ramaddr, x_addr); end
      if (phase == 1 && k_write) begin
        checks++; if (ramstore !== x_store) begin errors++; $display("FAIL rnd_store c%0d got %h exp %h", c, ramstore, x_store); end
      end
      checks++; if (ihit !== ((phase == 2) && !k_data)) begin errors++; $display("FAIL rnd_ihit c%0d got %b exp %b", c, ihit, (phase == 2) && !k_data); end
      checks++; if (dhit !== ((phase == 2) && k_data)) begin errors++; $display("FAIL rnd_dhit c%0d got %b exp %b", c, dhit, (phase == 2) && k_data); end
      checks++; if (iload !== x_iload) begin errors++; $display("FAIL rnd_iload c%0d got %h exp %h", c, iload, x_iload); end
      checks++; if (dload !== x_dload) begin errors++; $display("FAIL rnd_dload c%0d got %h exp %h", c, dload, x_dload); end

      // Requester: retire on hit, then maybe raise a fresh request.
      if (phase == 2) begin
        if (k_data) begin d_req = 1'b0; dREN = 1'b0; dWEN = 1'b0; end
        else begin i_req = 1'b0; iREN = 1'b0; end
      end
      if (!i_req && $urandom_range(2, 0) == 0) begin
        i_req = 1'b1; iREN = 1'b1;
        iaddr = {26'd0, 4'($urandom_range(15, 0)), 2'b00};
      end
      if (!d_req && $urandom_range(2, 0) == 0) begin
        op = $urandom_range(2, 0);
        d_req = 1'b1; dREN = (op != 1); dWEN = (op != 0);
        daddr = {26'd0, 4'($urandom_range(15, 0)), 2'b00};
        dstore = $urandom;
      end

      // RAM behaviour and expectation for the next cycle.
      case (phase)
        0: begin
          ramready = 1'($urandom_range(1, 0)); ramload = $urandom;
          if (d_req && !owed) begin
            k_data = 1'b1; k_write = dWEN; x_addr = daddr; x_store = dstore;
            owed = i_req; phase = 1; waits = $urandom_range(3, 0);
          end else if (i_req) begin
            k_data = 1'b0; k_write = 1'b0; x_addr = iaddr;
            owed = 1'b0; phase = 1; waits = $urandom_range(3, 0);
          end
        end
        1: begin
          if (waits == 0) begin
            ramready = 1'b1;
            ramload = k_write ? $urandom : ram_mem[ramaddr[5:2]];
            if (ramWEN) ram_mem[ramaddr[5:2]] = ramstore;
            if (k_write) ref_mem[x_addr[5:2]] = x_store;
            else if (k_data) x_dload = ref_mem[x_addr[5:2]];
            else x_iload = ref_mem[x_addr[5:2]];
            phase = 2;
          end else begin
            ramready = 1'b0; ramload = $urandom; waits--;
          end
        end
        default: begin
          ramready = 1'($urandom_range(1, 0)); ramload = $urandom;
          phase = 0;
        end
      endcase
      step();
    end
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_iread();
    test_dwrite();
    test_contention();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
